// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - reset, run and verdict engine for the RV32I single-cycle core
module core_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 1000,
    parameter int unsigned HANG_CYCLES  = 4,
    parameter logic [31:0] TOHOST_ADDR  = 32'h0000_0FFC,
    parameter logic [31:0] PASS_CODE    = 32'h0000_0001,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      pc,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    output logic             core_rst,
    output logic [2:0]       status,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      result
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_RUN     = 3'd2,
        S_PASS    = 3'd3,
        S_FAIL    = 3'd4,
        S_TIMEOUT = 3'd5,
        S_HANG    = 3'd6
    } state_t;

    localparam logic [31:0]      HOLD_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]      HANG_LIM  = 32'(HANG_CYCLES);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);

    state_t           state;
    logic [31:0]      hold_cnt;
    logic [31:0]      hang_cnt;
    logic [31:0]      prev_pc;
    logic             first_run;
    logic [CNT_W-1:0] cc_next;
    logic             tohost_hit;
    logic             hang_hit;
    logic             timeout_hit;

    assign status = state;

    // Saturating count; the current RUN cycle is included in the timeout compare.
    assign cc_next     = (cycle_count == {CNT_W{1'b1}}) ? cycle_count : cycle_count + 1'b1;
    assign tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
    // hang_cnt holds the number of consecutive samples at the same pc value.
    assign hang_hit    = !first_run && (pc == prev_pc) && ((hang_cnt + 32'd1) >= HANG_LIM);
    assign timeout_hit = (cc_next >= MAX_C);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            core_rst    <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
            result      <= '0;
            hold_cnt    <= '0;
            hang_cnt    <= '0;
            prev_pc     <= '0;
            first_run   <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= S_RUN;
                        core_rst  <= 1'b1;
                        first_run <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    cycle_count <= cc_next;
                    first_run   <= 1'b0;
                    prev_pc     <= pc;
                    if (first_run || (pc != prev_pc)) begin
                        hang_cnt <= 32'd1;
                    end else begin
                        hang_cnt <= hang_cnt + 32'd1;
                    end
                    if (tohost_hit) begin
                        result   <= mem_wdata;
                        state    <= (mem_wdata == PASS_CODE) ? S_PASS : S_FAIL;
                        core_rst <= 1'b0;
                        done     <= 1'b1;
                    end else if (hang_hit) begin
                        state    <= S_HANG;
                        core_rst <= 1'b0;
                        done     <= 1'b1;
                    end else if (timeout_hit) begin
                        state    <= S_TIMEOUT;
                        core_rst <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and all terminal states launch a fresh run the same way.
                    if (start) begin
                        state       <= S_HOLD;
                        core_rst    <= 1'b0;
                        done        <= 1'b0;
                        cycle_count <= '0;
                        result      <= '0;
                        hold_cnt    <= '0;
                        hang_cnt    <= '0;
                        first_run   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - directed bench for core_run_ctrl
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic [2:0]  status;
    logic        done;
    logic [31:0] cycle_count;
    logic [31:0] result;
    logic        pc_hold;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    core_run_ctrl #(
        .RESET_CYCLES(2),
        .MAX_CYCLES  (20),
        .HANG_CYCLES (4),
        .TOHOST_ADDR (32'h0000_0FFC),
        .PASS_CODE   (32'h0000_0001),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pc         (pc),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst   (core_rst),
        .status     (status),
        .done       (done),
        .cycle_count(cycle_count),
        .result     (result)
    );

    task automatic step();
        @(posedge clk);
        #1;
        if (!pc_hold) pc = pc + 32'd4;
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1;
        step();
        step();
        total++; if (status !== 3'd0) begin bad++; $display("FAIL reset_status got=%0d want=0", status); end
        total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL reset_core_rst got=%0b want=0", core_rst); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cycle_count); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%0h want=0", result); end
        start = 1'b0; rst = 1'b1;
        step();
        total++; if (status !== 3'd0) begin bad++; $display("FAIL idle_hold got=%0d want=0", status); end
    endtask

    task automatic test_pass();
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (status !== 3'd1 || core_rst !== 1'b0) begin bad++; $display("FAIL pass_hold1 status=%0d core_rst=%0b want 1/0", status, core_rst); end
        step();
        total++; if (status !== 3'd1 || core_rst !== 1'b0) begin bad++; $display("FAIL pass_hold2 status=%0d core_rst=%0b want 1/0", status, core_rst); end
        step();
        total++; if (status !== 3'd2 || core_rst !== 1'b1 || cycle_count !== 32'd0) begin
            bad++; $display("FAIL pass_run_entry status=%0d core_rst=%0b count=%0d want 2/1/0", status, core_rst, cycle_count);
        end
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) begin mem_we = 1'b1; mem_addr = 32'h0FFC; mem_wdata = 32'h1; end
            step();
            if (k == 1) begin
                total++; if (cycle_count !== 32'd1) begin bad++; $display("FAIL pass_first_count got=%0d want=1", cycle_count); end
            end
        end
        mem_we = 1'b0;
        total++; if (status !== 3'd3) begin bad++; $display("FAIL pass_status got=%0d want=3", status); end
        total++; if (done !== 1'b1 || core_rst !== 1'b0) begin bad++; $display("FAIL pass_done done=%0b core_rst=%0b want 1/0", done, core_rst); end
        total++; if (result !== 32'd1) begin bad++; $display("FAIL pass_result got=%0h want=1", result); end
        total++; if (cycle_count !== 32'd10) begin bad++; $display("FAIL pass_count got=%0d want=10", cycle_count); end
        step();
        total++; if (cycle_count !== 32'd10 || status !== 3'd3) begin bad++; $display("FAIL pass_frozen count=%0d status=%0d want 10/3", cycle_count, status); end
    endtask

    task automatic test_restart();
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (status !== 3'd1 || cycle_count !== 32'd0 || result !== 32'd0 || done !== 1'b0) begin
            bad++; $display("FAIL restart_clear status=%0d count=%0d result=%0h done=%0b want 1/0/0/0", status, cycle_count, result, done);
        end
        step();
        step();
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin mem_we = 1'b1; mem_addr = 32'h0FFC; mem_wdata = 32'h55; end
            step();
        end
        mem_we = 1'b0;
        total++; if (status !== 3'd4 || result !== 32'h55 || cycle_count !== 32'd3) begin
            bad++; $display("FAIL restart_run status=%0d result=%0h count=%0d want 4/55/3", status, result, cycle_count);
        end
    endtask

    task automatic test_fail_code();
        launch();
        for (int k = 1; k <= 5; k++) begin
            mem_we = 1'b0;
            if (k == 3) begin mem_we = 1'b1; mem_addr = 32'h0FF8; mem_wdata = 32'h1; end
            if (k == 5) begin mem_we = 1'b1; mem_addr = 32'h0FFC; mem_wdata = 32'h7; end
            step();
            if (k == 3) begin
                total++; if (status !== 3'd2) begin bad++; $display("FAIL fail_wrong_addr got=%0d want=2", status); end
            end
        end
        mem_we = 1'b0;
        total++; if (status !== 3'd4 || result !== 32'h7 || cycle_count !== 32'd5) begin
            bad++; $display("FAIL fail_code status=%0d result=%0h count=%0d want 4/7/5", status, result, cycle_count);
        end
    endtask

    task automatic test_timeout();
        launch();
        for (int k = 1; k <= 19; k++) step();
        total++; if (status !== 3'd2 || cycle_count !== 32'd19) begin bad++; $display("FAIL timeout_early status=%0d count=%0d want 2/19", status, cycle_count); end
        step();
        total++; if (status !== 3'd5 || cycle_count !== 32'd20 || done !== 1'b1) begin
            bad++; $display("FAIL timeout status=%0d count=%0d done=%0b want 5/20/1", status, cycle_count, done);
        end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL timeout_result got=%0h want=0", result); end
        step();
        total++; if (cycle_count !== 32'd20) begin bad++; $display("FAIL timeout_frozen got=%0d want=20", cycle_count); end
    endtask

    task automatic test_hang(input logic store_in_detect);
        launch();
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) begin pc_hold = 1'b1; pc = 32'h40; end
            if (k == 8 && store_in_detect) begin mem_we = 1'b1; mem_addr = 32'h0FFC; mem_wdata = 32'h1; end
            step();
            if (k == 7) begin
                total++; if (status !== 3'd2) begin bad++; $display("FAIL hang_early got=%0d want=2", status); end
            end
        end
        mem_we = 1'b0; pc_hold = 1'b0;
        if (store_in_detect) begin
            total++; if (status !== 3'd3 || result !== 32'd1) begin bad++; $display("FAIL hang_store status=%0d result=%0h want 3/1", status, result); end
        end else begin
            total++; if (status !== 3'd6 || done !== 1'b1) begin bad++; $display("FAIL hang status=%0d done=%0b want 6/1", status, done); end
        end
        total++; if (cycle_count !== 32'd8) begin bad++; $display("FAIL hang_count got=%0d want=8", cycle_count); end
    endtask

    task automatic test_reset_midrun();
        launch();
        for (int k = 1; k <= 6; k++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        total++; if (status !== 3'd0 || core_rst !== 1'b0 || cycle_count !== 32'd0 || done !== 1'b0) begin
            bad++; $display("FAIL midrun_reset status=%0d core_rst=%0b count=%0d done=%0b want 0/0/0/0", status, core_rst, cycle_count, done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (status !== 3'd1 || core_rst !== 1'b0) begin bad++; $display("FAIL midrun_hold1 status=%0d core_rst=%0b want 1/0", status, core_rst); end
        step();
        total++; if (status !== 3'd1 || core_rst !== 1'b0) begin bad++; $display("FAIL midrun_hold2 status=%0d core_rst=%0b want 1/0", status, core_rst); end
        step();
        total++; if (status !== 3'd2 || core_rst !== 1'b1) begin bad++; $display("FAIL midrun_run status=%0d core_rst=%0b want 2/1", status, core_rst); end
        step();
        total++; if (cycle_count !== 32'd1) begin bad++; $display("FAIL midrun_count got=%0d want=1", cycle_count); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; pc = 32'h1000; pc_hold = 1'b0;
        mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        test_reset();
        test_pass();
        test_restart();
        test_fail_code();
        test_timeout();
        test_hang(1'b0);
        test_hang(1'b1);
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Synthesizable run controller for the RV32I single-cycle core, replacing fixed-delay bench sequencing with a parametrised reset, run and verdict engine. It drives the core's active-low reset for a programmable number of cycles and counts run cycles. It detects program completion from a tohost store, a PC self-loop or a cycle timeout, and reports a latched verdict. It sits between the top-level clock/reset and `single_cycle_top`, and is usable both in simulation and on an FPGA with LEDs on `status`.

## Interface
- RESET_CYCLES, 2: cycles `core_rst` is held low after start; must be ≥1
- MAX_CYCLES, 1000: run-cycle budget before TIMEOUT; must be ≥1
- HANG_CYCLES, 4: consecutive cycles with unchanged `pc` that declare HANG; must be ≥2
- TOHOST_ADDR, 32'h0000_0FFC: data-memory address of the completion mailbox
- PASS_CODE, 32'h0000_0001: mailbox value meaning pass
- CNT_W, 32: width of `cycle_count`
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-low reset of this block
- start  in  1  level; launches a run when sampled high in IDLE or a terminal state
- pc  in  32  core program counter
- mem_we  in  1  core data-memory write enable
- mem_addr  in  32  core data-memory address
- mem_wdata  in  32  core data-memory write data
- core_rst  out  1  active-low reset to the core (registered)
- status  out  3  0 IDLE, 1 HOLD, 2 RUN, 3 PASS, 4 FAIL, 5 TIMEOUT, 6 HANG
- done  out  1  high in PASS/FAIL/TIMEOUT/HANG
- cycle_count  out  CNT_W  RUN cycles elapsed
- result  out  32  captured mailbox value

## Operation
- Reset (`rst`=0 at an edge):
  - state IDLE, `core_rst`=0, `done`=0, `cycle_count`=0, `result`=0.
  - Hang counter and previous-PC register cleared.
  - Applies from any state, mid-run included.
- IDLE: `core_rst`=0. `start`=1 → HOLD. On that transition: `cycle_count`←0, `result`←0, hold counter←0.
- HOLD: `core_rst`=0. Hold counter increments each cycle. After exactly RESET_CYCLES cycles in HOLD → RUN. `start` is ignored.
- RUN: `core_rst`=1, and each RUN cycle increments `cycle_count` by 1. Checks are evaluated in priority order; the first match wins:
  1. `mem_we`=1 and `mem_addr`==TOHOST_ADDR: `result`←`mem_wdata`, then → PASS if `mem_wdata`==PASS_CODE, else → FAIL.
  2. `pc` equal to the previous cycle's `pc` for HANG_CYCLES consecutive samples → HANG.
  3. `cycle_count` reaches MAX_CYCLES → TIMEOUT.
- Hang counter:
  - Resets to 1 whenever `pc` differs from the previous sample.
  - The first RUN cycle only loads the previous-PC register.
- Terminal states (PASS/FAIL/TIMEOUT/HANG):
  - `core_rst`=0 to freeze the core; `done`=1.
  - `cycle_count` and `result` are frozen.
  - `start`=1 → HOLD (restart, counters cleared as from IDLE).
- `start` held continuously high causes back-to-back runs. A bench deasserts it after `done`.
- `cycle_count` saturates at all-ones and never wraps.

## Timing
- All outputs are registered and change only on the rising `clk` edge.
- Start latency:
  - `start` sampled at edge N → `status`=1 after edge N.
  - `core_rst` rises after edge N+RESET_CYCLES; `status`=2 from that point.
- The first core-active cycle is counted: `cycle_count`=1 after the first RUN edge.
- Tohost store sampled at edge M → `status`/`done`/`result` valid after edge M. The store cycle itself is counted in `cycle_count`.
- TIMEOUT: `done` rises after the edge at which `cycle_count` becomes MAX_CYCLES.
- Tohost store in the same cycle as the timeout or hang condition → PASS/FAIL.
- `rst`=0 in the same cycle as `start`=1 → reset wins.

## Test plan
- Basic pass:
  - Stimulus: `rst` low 2 cycles, `start` pulse; in RUN cycle 10, `mem_we`=1, `mem_addr`=0xFFC, `mem_wdata`=1.
  - Required: `core_rst` low exactly 2 cycles after start; `status`=3, `done`=1, `result`=1, `cycle_count`=10, `core_rst`=0.
- Fail code: tohost write of 0x0000_0007 → `status`=4, `result`=7. A write to 0xFF8 in an earlier cycle is ignored.
- Timeout: MAX_CYCLES=20, `pc` incrementing by 4, no tohost write → `status`=5 with `cycle_count`=20 exactly; `result`=0.
- Hang: `pc` stuck at 0x40 from RUN cycle 5, HANG_CYCLES=4 → `status`=6 within 4 cycles of the first repeated value. A tohost write in the detection cycle yields PASS instead.
- Reset mid-run: `rst`=0 at RUN cycle 7 → next edge `status`=0, `core_rst`=0, `cycle_count`=0. A subsequent `start` runs a clean HOLD of RESET_CYCLES.
- Restart from terminal: `start` in PASS → `status`=1, `cycle_count`=0, `result`=0, and the second run completes independently.
